// File: rtl/dct_ctrl_pkg.sv
// Shared definitions for the DCT multiply-accumulate unit controllers.
// Used by every dct_unit sequencer instance.
package dct_ctrl_pkg;

    localparam int unsigned DCT_N_TAPS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage : dct_ctrl_pkg

// File: rtl/dct_mac_valid_pipe.sv
// Beat/first-tap shift register that lines accumulator enables up with
// products leaving the macu multiplier MULT_LAT cycles after mult_en.
module dct_mac_valid_pipe #(
    parameter int unsigned MULT_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic beat,
    input  logic first,
    output logic acc_en,
    output logic acc_clr,
    output logic pipe_empty
);

    logic [MULT_LAT-1:0] vld_q;
    logic [MULT_LAT-1:0] fst_q;
    logic [MULT_LAT-1:0] vld_d;
    logic [MULT_LAT-1:0] fst_d;

    // Stage 0 takes the new beat; older beats move one stage toward the output.
    if (MULT_LAT == 1) begin : g_single
        assign vld_d      = beat;
        assign fst_d      = beat & first;
        // Nothing can sit behind the output stage in a one-deep pipe.
        assign pipe_empty = 1'b1;
    end else begin : g_multi
        assign vld_d      = {vld_q[MULT_LAT-2:0], beat};
        assign fst_d      = {fst_q[MULT_LAT-2:0], beat & first};
        assign pipe_empty = ~|vld_q[MULT_LAT-2:0];
    end

    // The whole pipe freezes with ena so a resumed sequence stays cycle-exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            fst_q <= '0;
        end else if (ena) begin
            vld_q <= vld_d;
            fst_q <= fst_d;
        end
    end

    always_comb begin
        acc_en  = ena & vld_q[MULT_LAT-1];
        acc_clr = ena & vld_q[MULT_LAT-1] & fst_q[MULT_LAT-1];
    end

endmodule : dct_mac_valid_pipe

// File: rtl/dct_mac_sequencer.sv
// Control sequencer for one DCT macu: counts N_TAPS samples per coefficient,
// drives coef/mult/accumulator controls and a valid/ready result handshake.
module dct_mac_sequencer
    import dct_ctrl_pkg::*;
#(
    parameter int unsigned N_TAPS   = DCT_N_TAPS,
    parameter int unsigned CNT_W    = $clog2(N_TAPS),
    parameter int unsigned MULT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CNT_W-1:0] coef_sel,
    output logic             mult_en,
    output logic             acc_en,
    output logic             acc_clr,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] tap_cnt_q;
    logic             beat;
    logic             last_beat;
    logic             pipe_empty;
    logic             drain_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Tap counter; beat is already qualified by ena, so it freezes with the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt_q <= '0;
        end else if (beat) begin
            tap_cnt_q <= last_beat ? '0 : tap_cnt_q + CNT_W'(1);
        end
    end

    // Output decode; in_ready is held low while reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = rst_n & ena;
            RUN:     in_ready  = rst_n & ena;
            HOLD:    res_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
        busy      = (state_q != IDLE);
        beat      = in_valid & in_ready;
        last_beat = beat & (tap_cnt_q == LAST_TAP);
        mult_en   = beat;
        coef_sel  = tap_cnt_q;
    end

    // The final accumulate is the one leaving the pipe with nothing behind it.
    assign drain_done = acc_en & pipe_empty;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (beat)              state_d = RUN;
            RUN:     if (last_beat)         state_d = DRAIN;
            DRAIN:   if (drain_done)        state_d = HOLD;
            HOLD:    if (ena && res_ready)  state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    dct_mac_valid_pipe #(
        .MULT_LAT (MULT_LAT)
    ) u_valid_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .beat       (beat),
        .first      (tap_cnt_q == '0),
        .acc_en     (acc_en),
        .acc_clr    (acc_clr),
        .pipe_empty (pipe_empty)
    );

endmodule : dct_mac_sequencer

// File: tb/tb_dct_mac_sequencer.sv
// Directed table-driven bench for dct_mac_sequencer (MULT_LAT=1) plus a
// randomized event-timing model for a MULT_LAT=3 instance.
module tb_dct_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena, in_valid, res_ready;
    logic       in_ready, mult_en, acc_en, acc_clr, res_valid, busy;
    logic [2:0] coef_sel;

    logic       ena3, iv3, rr3;
    logic       in_ready3, mult_en3, acc_en3, acc_clr3, res_valid3, busy3;
    logic [2:0] coef_sel3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dct_mac_sequencer #(.N_TAPS(8), .MULT_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid),
        .in_ready(in_ready), .coef_sel(coef_sel), .mult_en(mult_en),
        .acc_en(acc_en), .acc_clr(acc_clr), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy)
    );

    dct_mac_sequencer #(.N_TAPS(8), .MULT_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena3), .in_valid(iv3),
        .in_ready(in_ready3), .coef_sel(coef_sel3), .mult_en(mult_en3),
        .acc_en(acc_en3), .acc_clr(acc_clr3), .res_valid(res_valid3),
        .res_ready(rr3), .busy(busy3)
    );

    typedef struct {
        logic       ena;
        logic       iv;
        logic       rr;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Output vector order: in_ready, coef_sel[2:0], mult_en, acc_en, acc_clr, res_valid, busy
    function automatic logic [8:0] ex(input logic ir, input logic [2:0] cs, input logic me,
                                      input logic ae, input logic ac, input logic rv,
                                      input logic bs);
        return {ir, cs, me, ae, ac, rv, bs};
    endfunction

    function automatic logic [8:0] got1();
        return {in_ready, coef_sel, mult_en, acc_en, acc_clr, res_valid, busy};
    endfunction

    function automatic logic [8:0] got3();
        return {in_ready3, coef_sel3, mult_en3, acc_en3, acc_clr3, res_valid3, busy3};
    endfunction

    task automatic add(input logic e, input logic v, input logic r, input logic [8:0] x);
        vec_t t;
        t.ena = e; t.iv = v; t.rr = r; t.exp = x;
        tbl.push_back(t);
    endtask

    task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b exp=%b (ir,cs[3],me,ae,ac,rv,busy)", nm, got, exp);
    endtask

    task automatic run_tbl(input string nm);
        foreach (tbl[i]) begin
            @(negedge clk);
            ena       = tbl[i].ena;
            in_valid  = tbl[i].iv;
            res_ready = tbl[i].rr;
            #1;
            check($sformatf("%s[%0d]", nm, i), got1(), tbl[i].exp);
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; res_ready = 1'b1;
        ena3 = 1'b1; iv3 = 1'b0; rr3 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic acc_exp [0:255];
    logic clr_exp [0:255];

    initial begin
        ena = 1'b1; in_valid = 1'b1; res_ready = 1'b1;
        ena3 = 1'b1; iv3 = 1'b1; rr3 = 1'b1;
        #2;
        check("reset_state", got1(), ex(0, 0, 0, 0, 0, 0, 0));
        check("reset_state3", got3(), ex(0, 0, 0, 0, 0, 0, 0));

        // Back-to-back beats: acc_en one cycle behind, result at t=9 for one cycle.
        do_reset();
        add(1, 1, 1, ex(1, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k < 8; k++) add(1, 1, 1, ex(1, 3'(k), 1, 1, k == 1, 0, 1));
        add(1, 0, 1, ex(0, 0, 0, 1, 0, 0, 1));
        add(1, 0, 1, ex(0, 0, 0, 0, 0, 1, 1));
        add(1, 0, 1, ex(1, 0, 0, 0, 0, 0, 0));
        run_tbl("b2b");

        // Beat every other cycle.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            add(1, 1, 1, ex(1, 3'(k), 1, 0, 0, 0, k > 0));
            if (k < 7) add(1, 0, 1, ex(1, 3'(k + 1), 0, 1, k == 0, 0, 1));
            else       add(1, 0, 1, ex(0, 0, 0, 1, 0, 0, 1));
        end
        add(1, 0, 1, ex(0, 0, 0, 0, 0, 1, 1));
        add(1, 0, 1, ex(1, 0, 0, 0, 0, 0, 0));
        run_tbl("gaps");

        // Backpressure in HOLD; offered samples must be ignored.
        do_reset();
        add(1, 1, 0, ex(1, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k < 8; k++) add(1, 1, 0, ex(1, 3'(k), 1, 1, k == 1, 0, 1));
        add(1, 0, 0, ex(0, 0, 0, 1, 0, 0, 1));
        for (int k = 0; k < 5; k++) add(1, 1, 0, ex(0, 0, 0, 0, 0, 1, 1));
        add(1, 0, 1, ex(0, 0, 0, 0, 0, 1, 1));
        add(1, 1, 1, ex(1, 0, 1, 0, 0, 0, 0));
        run_tbl("hold");

        // Freeze for 3 cycles after tap 3, then resume.
        do_reset();
        add(1, 1, 1, ex(1, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k < 4; k++) add(1, 1, 1, ex(1, 3'(k), 1, 1, k == 1, 0, 1));
        for (int k = 0; k < 3; k++) add(0, 1, 1, ex(0, 4, 0, 0, 0, 0, 1));
        for (int k = 4; k < 8; k++) add(1, 1, 1, ex(1, 3'(k), 1, 1, 0, 0, 1));
        add(1, 0, 1, ex(0, 0, 0, 1, 0, 0, 1));
        add(0, 0, 1, ex(0, 0, 0, 0, 0, 1, 1));
        add(1, 0, 1, ex(0, 0, 0, 0, 0, 1, 1));
        add(1, 0, 1, ex(1, 0, 0, 0, 0, 0, 0));
        run_tbl("freeze");

        // Asynchronous reset in the middle of a result.
        do_reset();
        add(1, 1, 1, ex(1, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k < 6; k++) add(1, 1, 1, ex(1, 3'(k), 1, 1, k == 1, 0, 1));
        run_tbl("pre_rst");
        @(negedge clk);
        #1;
        check("rst_pre", got1(), ex(1, 6, 1, 1, 0, 0, 1));
        rst_n = 1'b0;
        #1;
        check("rst_async", got1(), ex(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        add(1, 1, 1, ex(1, 0, 1, 0, 0, 0, 0));
        add(1, 0, 1, ex(1, 1, 0, 1, 1, 0, 1));
        run_tbl("post_rst");

        // MULT_LAT=3 with random in_valid/res_ready against an event-time model.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            acc_exp[i] = 1'b0;
            clr_exp[i] = 1'b0;
        end
        begin
            int   taps   = 0;
            int   res_t  = -1;
            logic accept = 1'b1;
            logic hold   = 1'b0;
            logic bt;
            for (int c = 0; c < 160; c++) begin
                @(negedge clk);
                iv3 = ($urandom_range(0, 9) < 7);
                rr3 = ($urandom_range(0, 9) < 5);
                #1;
                if (!accept && !hold && c == res_t) hold = 1'b1;
                bt = iv3 & accept;
                check($sformatf("lat3[%0d]", c), got3(),
                      ex(accept, 3'(taps), bt, acc_exp[c], clr_exp[c], hold,
                         !(accept && taps == 0)));
                if (hold && rr3) begin
                    hold   = 1'b0;
                    accept = 1'b1;
                end
                if (bt) begin
                    acc_exp[c + 3] = 1'b1;
                    clr_exp[c + 3] = (taps == 0);
                    if (taps == 7) begin
                        accept = 1'b0;
                        res_t  = c + 4;
                        taps   = 0;
                    end else begin
                        taps++;
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dct_mac_sequencer
